// File: rtl/upmixer_pkg.sv
// Shared widths and helpers for the four-lane complex-to-real upmixer.
// Latency/backpressure: not applicable (constants and functions only).
package upmixer_pkg;
    localparam int LANES       = 4;
    localparam int SAMPLE_W    = 16;
    localparam int NCO_W       = 16;
    localparam int PROD_W      = 32;
    localparam int DIFF_W      = PROD_W + 1;
    localparam int DAC_W       = 12;
    localparam int ROUND_SHIFT = 19;
    localparam int SAT_CNT_W   = 16;
    localparam int EVT_W       = $clog2(LANES + 1);

    function automatic logic [EVT_W-1:0] count_ones(input logic [LANES-1:0] v);
        logic [EVT_W-1:0] c;
        c = '0;
        for (int n = 0; n < LANES; n++) begin
            c = c + EVT_W'(v[n]);
        end
        return c;
    endfunction
endpackage

// File: rtl/upmixer_lane.sv
// One lane of d = i*cos - q*sin with round-half-up to 12 bits and saturation flag.
// Latency 3 cycles (products, difference, round/saturate); no backpressure.
module upmixer_lane
    import upmixer_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [SAMPLE_W-1:0] i_smp,
    input  logic signed [SAMPLE_W-1:0] q_smp,
    input  logic signed [NCO_W-1:0]    cos_nco,
    input  logic signed [NCO_W-1:0]    sin_nco,
    input  logic                       smp_vld,
    output logic signed [DAC_W-1:0]    dac,
    output logic                       dac_vld,
    output logic                       sat
);
    localparam int RND_W = DIFF_W - ROUND_SHIFT + 1;
    localparam logic signed [DIFF_W:0]    HALF    = (DIFF_W + 1)'(1) << (ROUND_SHIFT - 1);
    localparam logic signed [RND_W-1:0]   RND_MAX = RND_W'((2 ** (DAC_W - 1)) - 1);
    localparam logic signed [RND_W-1:0]   RND_MIN = RND_W'(-(2 ** (DAC_W - 1)));

    logic signed [PROD_W-1:0] prod_ic;
    logic signed [PROD_W-1:0] prod_qs;
    logic signed [DIFF_W-1:0] diff;
    logic        [2:0]        vld_sr;
    logic signed [DIFF_W:0]   biased;
    logic signed [RND_W-1:0]  rnd;
    logic signed [DAC_W-1:0]  sat_val;
    logic                     sat_c;

    // Bias by half an LSB then arithmetic-shift: floor((d + 2^18) / 2^19).
    always_comb begin
        biased  = {diff[DIFF_W-1], diff} + HALF;
        rnd     = RND_W'(biased >>> ROUND_SHIFT);
        sat_c   = 1'b0;
        sat_val = rnd[DAC_W-1:0];
        if (rnd > RND_MAX) begin
            sat_c   = 1'b1;
            sat_val = {1'b0, {(DAC_W - 1){1'b1}}};
        end else if (rnd < RND_MIN) begin
            sat_c   = 1'b1;
            sat_val = {1'b1, {(DAC_W - 1){1'b0}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_ic <= '0;
            prod_qs <= '0;
            diff    <= '0;
            vld_sr  <= '0;
            dac     <= '0;
            sat     <= 1'b0;
        end else begin
            prod_ic <= PROD_W'(i_smp) * PROD_W'(cos_nco);
            prod_qs <= PROD_W'(q_smp) * PROD_W'(sin_nco);
            diff    <= {prod_ic[PROD_W-1], prod_ic} - {prod_qs[PROD_W-1], prod_qs};
            vld_sr  <= {vld_sr[1:0], smp_vld};
            sat     <= vld_sr[1] & sat_c;
            if (vld_sr[1]) begin
                dac <= sat_val;
            end
        end
    end

    assign dac_vld = vld_sr[2];
endmodule

// File: rtl/upmixer.sv
// Four independent upconversion lanes feeding the DACs plus a saturating event counter.
// Latency 3 cycles per lane (counter one more); no backpressure, downstream always accepts.
module upmixer
    import upmixer_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic signed [SAMPLE_W-1:0]  i0_i,
    input  logic signed [SAMPLE_W-1:0]  i1_i,
    input  logic signed [SAMPLE_W-1:0]  i2_i,
    input  logic signed [SAMPLE_W-1:0]  i3_i,
    input  logic signed [SAMPLE_W-1:0]  q0_i,
    input  logic signed [SAMPLE_W-1:0]  q1_i,
    input  logic signed [SAMPLE_W-1:0]  q2_i,
    input  logic signed [SAMPLE_W-1:0]  q3_i,
    input  logic signed [NCO_W-1:0]     cos0_i,
    input  logic signed [NCO_W-1:0]     cos1_i,
    input  logic signed [NCO_W-1:0]     cos2_i,
    input  logic signed [NCO_W-1:0]     cos3_i,
    input  logic signed [NCO_W-1:0]     sin0_i,
    input  logic signed [NCO_W-1:0]     sin1_i,
    input  logic signed [NCO_W-1:0]     sin2_i,
    input  logic signed [NCO_W-1:0]     sin3_i,
    input  logic        [LANES-1:0]     valid_i,
    input  logic                        sat_clr_i,
    output logic signed [DAC_W-1:0]     dac0_o,
    output logic signed [DAC_W-1:0]     dac1_o,
    output logic signed [DAC_W-1:0]     dac2_o,
    output logic signed [DAC_W-1:0]     dac3_o,
    output logic        [LANES-1:0]     valid_o,
    output logic        [SAT_CNT_W-1:0] sat_cnt_o
);
    logic signed [SAMPLE_W-1:0] i_arr   [LANES];
    logic signed [SAMPLE_W-1:0] q_arr   [LANES];
    logic signed [NCO_W-1:0]    cos_arr [LANES];
    logic signed [NCO_W-1:0]    sin_arr [LANES];
    logic signed [DAC_W-1:0]    dac_arr [LANES];
    logic        [LANES-1:0]    sat_vec;
    logic        [EVT_W-1:0]    evt;
    logic        [SAT_CNT_W:0]  sum;

    assign i_arr   = '{i0_i, i1_i, i2_i, i3_i};
    assign q_arr   = '{q0_i, q1_i, q2_i, q3_i};
    assign cos_arr = '{cos0_i, cos1_i, cos2_i, cos3_i};
    assign sin_arr = '{sin0_i, sin1_i, sin2_i, sin3_i};

    assign dac0_o = dac_arr[0];
    assign dac1_o = dac_arr[1];
    assign dac2_o = dac_arr[2];
    assign dac3_o = dac_arr[3];

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        upmixer_lane u_lane (
            .clk     (clk_i),
            .rst     (rst_i),
            .i_smp   (i_arr[n]),
            .q_smp   (q_arr[n]),
            .cos_nco (cos_arr[n]),
            .sin_nco (sin_arr[n]),
            .smp_vld (valid_i[n]),
            .dac     (dac_arr[n]),
            .dac_vld (valid_o[n]),
            .sat     (sat_vec[n])
        );
    end

    assign evt = count_ones(sat_vec);
    assign sum = {1'b0, sat_cnt_o} + (SAT_CNT_W + 1)'(evt);

    // A clear coinciding with events restarts the count from this cycle's events.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sat_cnt_o <= '0;
        end else if (sat_clr_i) begin
            sat_cnt_o <= SAT_CNT_W'(evt);
        end else if (sum[SAT_CNT_W]) begin
            sat_cnt_o <= '1;
        end else begin
            sat_cnt_o <= sum[SAT_CNT_W-1:0];
        end
    end
endmodule

// File: tb/tb_upmixer.sv
// Directed vector table plus hand-written sequences for counter clear/clamp, burst hold and reset.
module tb_upmixer;
    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] iv [4];
    logic signed [15:0] qv [4];
    logic signed [15:0] cv [4];
    logic signed [15:0] sv [4];
    logic        [3:0]  valid_i;
    logic               sat_clr;
    logic signed [11:0] dac [4];
    logic        [3:0]  valid_o;
    logic        [15:0] sat_cnt;

    int total = 0;
    int bad   = 0;
    int exp_cnt;
    int hold [4];

    typedef struct {
        int lane;
        int i;
        int q;
        int c;
        int s;
        int exp_dac;
        int exp_sat;
    } vec_t;

    vec_t vt [11];

    always #5 clk = ~clk;

    upmixer dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .i0_i      (iv[0]),
        .i1_i      (iv[1]),
        .i2_i      (iv[2]),
        .i3_i      (iv[3]),
        .q0_i      (qv[0]),
        .q1_i      (qv[1]),
        .q2_i      (qv[2]),
        .q3_i      (qv[3]),
        .cos0_i    (cv[0]),
        .cos1_i    (cv[1]),
        .cos2_i    (cv[2]),
        .cos3_i    (cv[3]),
        .sin0_i    (sv[0]),
        .sin1_i    (sv[1]),
        .sin2_i    (sv[2]),
        .sin3_i    (sv[3]),
        .valid_i   (valid_i),
        .sat_clr_i (sat_clr),
        .dac0_o    (dac[0]),
        .dac1_o    (dac[1]),
        .dac2_o    (dac[2]),
        .dac3_o    (dac[3]),
        .valid_o   (valid_o),
        .sat_cnt_o (sat_cnt)
    );

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_lane(input int l, input int i, input int q, input int c, input int s);
        iv[l] = 16'(i);
        qv[l] = 16'(q);
        cv[l] = 16'(c);
        sv[l] = 16'(s);
    endtask

    task automatic all_sat_pulse();
        for (int l = 0; l < 4; l++) set_lane(l, -32768, 32767, -32768, -32768);
        valid_i = 4'b1111;
        @(negedge clk);
        valid_i = 4'b0000;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        vt[0]  = '{0,  16384,     0,  32767,      0,  1024, 0};
        vt[1]  = '{1, -32768, 32767, -32768, -32768,  2047, 1};
        vt[2]  = '{2, -32768,     0,  32767,      0, -2048, 0};
        vt[3]  = '{3, -32768, 32767,  32767,  32767, -2048, 1};
        vt[4]  = '{0,      0, 16384,      0,  16384,  -512, 0};
        vt[5]  = '{1,    512,     0,    512,      0,     1, 0};
        vt[6]  = '{2,   -512,     0,    512,      0,     0, 0};
        vt[7]  = '{3,      0,     1,      0,      1,     0, 0};
        vt[8]  = '{3,    -13,     0,  20165,      0,    -1, 0};
        vt[9]  = '{0, -32768,   512, -32768,    512,  2047, 1};
        vt[10] = '{1, -32768,   512, -32768,    513,  2047, 0};

        rst     = 1'b1;
        sat_clr = 1'b0;
        valid_i = 4'b1111;
        for (int l = 0; l < 4; l++) begin
            set_lane(l, -32768, 32767, -32768, -32768);
            hold[l] = 0;
        end
        repeat (4) @(negedge clk);
        chk("rst_valid_o", valid_o, 0);
        chk("rst_sat_cnt", sat_cnt, 0);
        for (int l = 0; l < 4; l++) chk("rst_dac", dac[l], 0);
        valid_i = 4'b0000;
        rst     = 1'b0;
        exp_cnt = 0;
        repeat (2) @(negedge clk);
        chk("post_rst_valid_o", valid_o, 0);

        for (int k = 0; k < 11; k++) begin
            set_lane(vt[k].lane, vt[k].i, vt[k].q, vt[k].c, vt[k].s);
            valid_i = 4'(1 << vt[k].lane);
            @(negedge clk);
            valid_i = 4'b0000;
            chk("lat1_valid_o", valid_o, 0);
            @(negedge clk);
            chk("lat2_valid_o", valid_o, 0);
            @(negedge clk);
            chk("lat3_valid_o", valid_o, 32'(1 << vt[k].lane));
            chk("vec_dac", dac[vt[k].lane], vt[k].exp_dac);
            hold[vt[k].lane] = vt[k].exp_dac;
            for (int l = 0; l < 4; l++) begin
                if (l != vt[k].lane) chk("vec_hold", dac[l], hold[l]);
            end
            @(negedge clk);
            exp_cnt += vt[k].exp_sat;
            chk("vec_sat_cnt", sat_cnt, exp_cnt);
            chk("vec_valid_o_low", valid_o, 0);
        end

        // Four simultaneous saturations with clear asserted: counter loads 4.
        for (int l = 0; l < 4; l++) set_lane(l, -32768, 32767, -32768, -32768);
        valid_i = 4'b1111;
        @(negedge clk);
        valid_i = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        chk("clr_valid_o", valid_o, 15);
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        chk("clr_load_events", sat_cnt, 4);
        for (int l = 0; l < 4; l++) hold[l] = 2047;
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        chk("clr_no_events", sat_cnt, 0);

        // Run the counter up to 65532 then push it past the ceiling twice.
        valid_i = 4'b1111;
        repeat (16383) @(negedge clk);
        valid_i = 4'b0000;
        repeat (4) @(negedge clk);
        chk("preset_cnt", sat_cnt, 65532);
        all_sat_pulse();
        chk("clamp_cnt", sat_cnt, 65535);
        all_sat_pulse();
        chk("clamp_hold_cnt", sat_cnt, 65535);

        // Burst on lanes 1 and 3 only; lanes 0 and 2 carry data but must hold.
        set_lane(0, 4096, 0, 32767, 0);
        set_lane(2, 4096, 0, 32767, 0);
        for (int cyc = 0; cyc < 9; cyc++) begin
            if (cyc >= 3 && cyc < 8) begin
                chk("burst_valid_o", valid_o, 10);
                chk("burst_dac1", dac[1], cyc - 2);
                chk("burst_dac3", dac[3], -(cyc - 2));
            end else begin
                chk("burst_idle_valid_o", valid_o, 0);
            end
            chk("burst_hold0", dac[0], 2047);
            chk("burst_hold2", dac[2], 2047);
            if (cyc < 5) begin
                set_lane(1,  1024 * (cyc + 1), 0, 512, 0);
                set_lane(3, -1024 * (cyc + 1), 0, 512, 0);
                valid_i = 4'b1010;
            end else begin
                valid_i = 4'b0000;
            end
            @(negedge clk);
        end
        chk("burst_sat_cnt", sat_cnt, 65535);

        // Reset asserted while samples are in flight.
        for (int k = 6; k < 9; k++) begin
            set_lane(1, 1024 * k, 0, 512, 0);
            valid_i = 4'b1010;
            @(negedge clk);
        end
        chk("pre_rst_dac1", dac[1], 6);
        chk("pre_rst_valid_o", valid_o, 10);
        set_lane(1, 1024 * 9, 0, 512, 0);
        set_lane(3, -1024 * 9, 0, 512, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid_o", valid_o, 0);
        chk("mid_rst_sat_cnt", sat_cnt, 0);
        for (int l = 0; l < 4; l++) chk("mid_rst_dac", dac[l], 0);
        @(negedge clk);
        @(negedge clk);
        chk("in_rst_valid_o", valid_o, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel1_valid_o", valid_o, 0);
        @(negedge clk);
        chk("rel2_valid_o", valid_o, 0);
        chk("rel2_dac1", dac[1], 0);
        @(negedge clk);
        valid_i = 4'b0000;
        chk("rel3_valid_o", valid_o, 10);
        chk("rel3_dac1", dac[1], 9);
        chk("rel3_dac3", dac[3], -9);
        chk("rel3_dac0", dac[0], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/upmixer.md
UPMIXER -- requirements
Module: upmixer

Interface
REQ-001 SHALL have port: clk_i  input  1  single clock; all registers on rising edge.
REQ-002 SHALL have port: rst_i  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: i0_i..i3_i  input  16 each  signed in-phase baseband, Q15, lanes 0..3.
REQ-004 SHALL have ports: q0_i..q3_i  input  16 each  signed quadrature baseband, Q15, lanes 0..3.
REQ-005 SHALL have ports: cos0_i..cos3_i, sin0_i..sin3_i  input  16 each  signed NCO carrier, Q15, per lane.
REQ-006 SHALL have port: valid_i  input  4  per-lane input-valid qualifier; bit n qualifies lane n.
REQ-007 SHALL have port: sat_clr_i  input  1  synchronous clear of the saturation counter.
REQ-008 SHALL have ports: dac0_o..dac3_o  output  12 each  signed real passband sample for the DAC, per lane.
REQ-009 SHALL have port: valid_o  output  4  per-lane output-valid; bit n qualifies dac<n>_o.
REQ-010 SHALL have port: sat_cnt_o  output  16  unsigned count of saturated output samples.

Function
REQ-011 SHALL compute per lane d = i*cos - q*sin: the complex-to-real upconversion inverse to the receive-side downmixer.
REQ-012 SHALL run a 3-stage pipeline per lane: S1 registers both 32-bit signed products; S2 registers 33-bit signed difference; S3 registers round+saturate result.
REQ-013 SHALL have latency exactly 3 clk_i cycles from valid_i[n] high to valid_o[n] high for that sample; throughput 1 sample/lane/cycle.
REQ-014 SHALL carry valid_i[n] through a 3-bit shift register alongside lane n data; lanes are fully independent.
REQ-015 SHALL round as r = floor((d + 2^18) / 2^19), i.e. round-half-up, keeping Q30 bits [30:19].
REQ-016 SHALL saturate r to [-2048, +2047]; saturated flag set when r was outside that range.
REQ-017 SHALL update dac<n>_o only when the S3 valid bit is high; otherwise dac<n>_o holds its last value and valid_o[n] is low.
REQ-018 SHALL increment sat_cnt_o by the number of lanes (0..4) that emit a saturated valid sample in that cycle; the counter saturates at 65535, no wrap.
REQ-019 SHALL, when sat_clr_i and saturation events coincide, load sat_cnt_o with that cycle's event count; with no events, clear to 0.
REQ-020 SHALL not use a handshake or backpressure; downstream always accepts.

Reset
REQ-021 SHALL, on rst_i high, asynchronously clear all pipeline data, valid shift bits, dac0_o..dac3_o, valid_o and sat_cnt_o to 0.
REQ-022 SHALL discard in-flight samples on reset mid-operation; after release, valid_o stays 0 until new valid_i propagates (3 cycles).

Structure
REQ-023 SHALL take LANES=4, SAMPLE_W=16, NCO_W=16, PROD_W=32, DAC_W=12, ROUND_SHIFT=19 and SAT_CNT_W=16 from shared package upmixer_pkg.
REQ-024 SHALL implement one lane (S1-S3, valid shift, saturate flag) as sub-module upmixer_lane, instantiated LANES times; counter logic stays in top.
REQ-025 SHALL keep multiplies behavioural so synthesis maps them to DSP48E1 with internal pipeline registers.

Verification
REQ-026 SHALL verify: lane0 i=16384, cos=32767, q=0, sin=0, valid_i=0001 -> 3 cycles later dac0_o=1024, valid_o=0001, sat_cnt_o=0.
REQ-027 SHALL verify: lane1 i=-32768, cos=-32768, q=32767, sin=-32768 -> dac1_o=+2047 and sat_cnt_o increments by 1.
REQ-028 SHALL verify: lane2 i=-32768, cos=32767, q=0, sin=0 -> dac2_o=-2048, not counted as saturation.
REQ-029 SHALL verify: all 4 lanes saturating on the same cycle with sat_clr_i high -> sat_cnt_o=4 next cycle; counter preset near 65535 stops at 65535.
REQ-030 SHALL verify: valid_i=1010 burst of 5 cycles -> only lanes 1,3 update, lanes 0,2 hold values; rst_i pulsed mid-burst -> all outputs 0 immediately, valid_o=0 for 3 cycles after release.
